// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - recovers an 8-bit duty sample from a fixed-period PWM waveform
module pwm_capture #(
  parameter int PERIOD      = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwm_in,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       locked,
  output logic       period_err
);

  typedef enum logic [1:0] {ACQUIRE, TRACK, STUCK} state_t;

  localparam logic [8:0] PERIOD_CNT = 9'(PERIOD);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic                   chg;
  logic                   run_done;
  logic [8:0]             per_cnt;
  logic [8:0]             run_cnt;
  logic [7:0]             hi_cnt;
  state_t                 state;

  assign pwm_s    = sync_q[SYNC_STAGES-1];
  assign rise     = pwm_s & ~pwm_d;
  assign chg      = pwm_s ^ pwm_d;
  assign run_done = ~chg & (run_cnt == PERIOD_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      pwm_d  <= pwm_s;
    end
  end

  // Counters restart on the edge that ends a measurement, so on a rise cycle they still hold the last period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      run_cnt <= '0;
    end else begin
      if (rise)
        per_cnt <= 9'd1;
      else if (per_cnt != 9'd511)
        per_cnt <= per_cnt + 9'd1;

      if (rise)
        hi_cnt <= 8'd1;
      else if (pwm_s && hi_cnt != 8'd255)
        hi_cnt <= hi_cnt + 8'd1;

      if (chg || run_done)
        run_cnt <= 9'd1;
      else
        run_cnt <= run_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACQUIRE;
      sample       <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
      period_err   <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      period_err   <= 1'b0;
      if (rise) begin
        if (state == TRACK) begin
          if (per_cnt == PERIOD_CNT) begin
            sample       <= hi_cnt;
            sample_valid <= 1'b1;
            locked       <= 1'b1;
          end else begin
            period_err <= 1'b1;
            locked     <= 1'b0;
          end
        end else if (state == STUCK) begin
          locked <= 1'b0;
        end
        state <= TRACK;
      end else if (run_done) begin
        // A full period without any edge means duty 0 or full scale
        sample       <= {8{pwm_s}};
        sample_valid <= 1'b1;
        locked       <= 1'b1;
        state        <= STUCK;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - randomized PWM stimulus checked against an event-level reference model
module tb_pwm_capture;

  localparam int PERIOD      = 255;
  localparam int SYNC_STAGES = 2;
  localparam int MAXC        = 65536;

  logic       clk = 1'b0;
  logic       rst;
  logic       pwm_in;
  logic [7:0] sample;
  logic       sample_valid;
  logic       locked;
  logic       period_err;

  pwm_capture #(.PERIOD(PERIOD), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .sample(sample),
    .sample_valid(sample_valid),
    .locked(locked),
    .period_err(period_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: input history indexed by clock edge, decisions from edge timestamps
  logic inh [MAXC];
  int   n         = 0;
  int   rst_last  = -1;
  int   anchor    = 0;
  int   last_rise = -1;
  int   st        = 0;
  int   e_sample  = 0;
  int   e_valid   = 0;
  int   e_locked  = 0;
  int   e_err     = 0;

  function automatic logic lv(input int m);
    if (m < 0 || m <= rst_last) return 1'b0;
    return inh[m];
  endfunction

  always @(posedge clk) begin
    logic s, d;
    int   per, hi;
    if (n < MAXC) inh[n] = pwm_in;
    e_valid = 0;
    e_err   = 0;
    if (rst) begin
      rst_last  = n;
      anchor    = n + 1;
      last_rise = -1;
      st        = 0;
      e_sample  = 0;
      e_locked  = 0;
    end else begin
      s = lv(n - SYNC_STAGES);
      d = lv(n - SYNC_STAGES - 1);
      if (s && !d) begin
        if (st == 1) begin
          per = n - last_rise;
          if (per > 511) per = 511;
          hi = 0;
          for (int m = last_rise; m < n; m++) hi += int'(lv(m - SYNC_STAGES));
          if (hi > 255) hi = 255;
          if (per == PERIOD) begin
            e_sample = hi; e_valid = 1; e_locked = 1;
          end else begin
            e_err = 1; e_locked = 0;
          end
        end else if (st == 2) begin
          e_locked = 0;
        end
        st = 1;
        last_rise = n;
      end else if (s == d && n - anchor == PERIOD) begin
        e_sample = s ? 255 : 0; e_valid = 1; e_locked = 1; st = 2;
      end
      if (s != d || n - anchor == PERIOD) anchor = n;
    end
    n++;
  end

  int vcount = 0;
  int ecount = 0;

  always @(negedge clk) begin
    if (sample_valid) vcount++;
    if (period_err) ecount++;
    if (rst) begin
      check("reset_out", int'({sample, sample_valid, locked, period_err}), 0);
    end else begin
      check("sample", int'(sample), e_sample);
      check("sample_valid", int'(sample_valid), e_valid);
      check("locked", int'(locked), e_locked);
      check("period_err", int'(period_err), e_err);
    end
  end

  task automatic drive(input logic v, input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1 pwm_in = v;
    end
  endtask

  task automatic pwm(input int per, input int duty, input int nper);
    repeat (nper) begin
      drive(1'b1, duty);
      drive(1'b0, per - duty);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_sample", int'(sample), 0);
    check("async_valid", int'(sample_valid), 0);
    check("async_locked", int'(locked), 0);
    check("async_err", int'(period_err), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    vcount = 0;
    pwm(PERIOD, 128, 5);
    check("d128_pulses", vcount, 4);
    check("d128_sample", int'(sample), 128);
    check("d128_locked", int'(locked), 1);

    drive(1'b0, 600);
    check("d0_sample", int'(sample), 0);
    check("d0_locked", int'(locked), 1);
    drive(1'b1, 20);
    check("d255_unlocked", int'(locked), 0);
    drive(1'b1, 280);
    check("d255_sample", int'(sample), 255);
    check("d255_locked", int'(locked), 1);

    vcount = 0;
    ecount = 0;
    pwm(PERIOD, 10, 3);
    pwm(PERIOD, 200, 3);
    check("step_pulses", vcount, 4);
    check("step_sample", int'(sample), 200);
    check("step_err", ecount, 0);

    pulse_reset();
    vcount = 0;
    ecount = 0;
    pwm(200, 50, 6);
    check("wrong_err", ecount, 5);
    check("wrong_valid", vcount, 0);
    check("wrong_sample", int'(sample), 0);
    check("wrong_locked", int'(locked), 0);

    pwm(PERIOD, 1, 3);
    check("duty1_sample", int'(sample), 1);
    check("duty1_locked", int'(locked), 1);
    pwm(PERIOD, 254, 3);
    check("duty254_sample", int'(sample), 254);
    check("duty254_locked", int'(locked), 1);

    pwm(PERIOD, 77, 3);
    check("pre_rst_sample", int'(sample), 77);
    check("pre_rst_locked", int'(locked), 1);
    drive(1'b1, 77);
    drive(1'b0, 40);
    pulse_reset();
    drive(1'b0, PERIOD - 77 - 40 - 4);
    vcount = 0;
    pwm(PERIOD, 77, 1);
    check("rst_first_valid", vcount, 0);
    check("rst_first_sample", int'(sample), 0);
    pwm(PERIOD, 77, 2);
    check("rst_second_valid", vcount, 2);
    check("rst_second_sample", int'(sample), 77);
    check("rst_second_locked", int'(locked), 1);

    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = $urandom_range(0, 7);
      if (kind <= 4) begin
        pwm(PERIOD, $urandom_range(1, 254), $urandom_range(1, 3));
      end else if (kind == 5) begin
        int p;
        p = $urandom_range(100, 400);
        pwm(p, p / 2, $urandom_range(1, 2));
      end else begin
        drive(kind[0], $urandom_range(100, 600));
      end
    end
    drive(1'b0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
